// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register target
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_t;

  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-FF synchronizer, FILT-sample stability filter and edge pulses
module i2c_line_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic f,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

  logic [1:0]    sync;
  logic          f_d;
  logic [CW-1:0] cnt;

  // The output only follows the synchronized level once it has differed for FILT samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      f    <= 1'b1;
      f_d  <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], pin};
      f_d  <= f;
      if (sync[1] == f) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        f   <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = f & ~f_d;
  assign fall = ~f & f_d;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a byte-wide register port with auto-incrementing pointer
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = I2C_DEFAULT_ADDR,
  parameter int         FILT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILT(FILT)) u_scl_filter (
    .clk  (clk),
    .reset(reset),
    .pin  (scl_i),
    .f    (scl_f),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(.FILT(FILT)) u_sda_filter (
    .clk  (clk),
    .reset(reset),
    .pin  (sda_i),
    .f    (sda_f),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  i2c_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic       load_pending;
  logic       inc_pending;

  logic start, stop, shift_en, byte_done;

  assign start     = sda_fall & scl_f;
  assign stop      = sda_rise & scl_f;
  assign shift_en  = scl_rise && (bit_cnt != 4'd8);
  assign byte_done = scl_fall && (bit_cnt == 4'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 8'd0;
      rw           <= 1'b0;
      sda_t        <= 1'b1;
      reg_addr     <= 8'd0;
      reg_wdata    <= 8'd0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      busy         <= 1'b0;
      load_pending <= 1'b0;
      inc_pending  <= 1'b0;
    end else begin
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      // Read data arrives the clk after reg_re; the pointer steps the clk after reg_we.
      load_pending <= reg_re;
      inc_pending  <= reg_we;
      if (load_pending) shreg <= reg_rdata;
      if (inc_pending) reg_addr <= reg_addr + 8'd1;

      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_t   <= 1'b1;
      end else if (stop) begin
        state <= ST_IDLE;
        sda_t <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (shift_en) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              bit_cnt <= 4'd0;
              if (shreg[7:1] == ADDR) begin
                sda_t <= 1'b0;
                busy  <= 1'b1;
                rw    <= shreg[0];
                state <= ST_ADDR_ACK;
                if (shreg[0] == I2C_RW_READ) reg_re <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw == I2C_RW_READ) begin
                sda_t   <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= 4'd1;
                state   <= ST_RDATA;
              end else begin
                sda_t   <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (shift_en) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              reg_addr <= shreg;
              sda_t    <= 1'b0;
              state    <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_t   <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (shift_en) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
              reg_wdata <= shreg;
              reg_we    <= 1'b1;
              sda_t     <= 1'b0;
              state     <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_t    <= 1'b1;
                reg_addr <= reg_addr + 8'd1;
                state    <= ST_RDATA_ACK;
              end else begin
                sda_t   <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                reg_re <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end else if (scl_fall) begin
              sda_t   <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= 4'd1;
              state   <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bench with write/read scoreboards for i2c_target_regs
module tb_i2c_target_regs;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_t;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  logic [7:0]  mem [256];
  logic [15:0] exp_we [$];
  logic [7:0]  exp_rd [$];
  logic [15:0] e_we;
  int n_cmp = 0;
  int n_fail = 0;
  int n_we = 0;
  int n_re = 0;
  bit sda_low_seen = 1'b0;

  always #20 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & sda_t;

  i2c_target_regs dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_t    (sda_t),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sda_t === 1'b0) sda_low_seen = 1'b1;
      if (reg_re) n_re++;
      if (reg_we) begin
        n_we++;
        if (exp_we.size() == 0) begin
          chk("we_unexpected", {reg_addr, reg_wdata}, 16'hFFFF);
        end else begin
          e_we = exp_we.pop_front();
          chk("we_data", {reg_addr, reg_wdata}, e_we);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic gscl, input logic gsda);
    sda_m = b;
    hw(H);
    scl_m = 1'b1;
    hw(H / 2);
    if (gscl) begin scl_m = 1'b0; hw(1); scl_m = 1'b1; end
    if (gsda) begin sda_m = ~b;   hw(1); sda_m = b;    end
    hw(H / 2);
    scl_m = 1'b0;
    hw(H);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    hw(H);
    scl_m = 1'b1;
    hw(H / 2);
    b = sda_i;
    hw(H / 2);
    scl_m = 1'b0;
    hw(H);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic [7:0] gscl, input logic [7:0] gsda,
                            output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], gscl[i], gsda[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) recv_bit(b[i]);
    send_bit(ack, 1'b0, 1'b0);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hw(H);
    scl_m = 1'b1; hw(H);
    sda_m = 1'b0; hw(H);
    scl_m = 1'b0; hw(H);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hw(H);
    scl_m = 1'b1; hw(H);
    sda_m = 1'b1; hw(2 * H);
  endtask

  logic       a;
  logic [7:0] rb;
  int         w0, r0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h3C;
    hw(4);
    chk("rst_sda_t", 16'(sda_t), 16'd1);
    chk("rst_reg_addr", 16'(reg_addr), 16'h00);
    chk("rst_reg_wdata", 16'(reg_wdata), 16'h00);
    chk("rst_reg_we", 16'(reg_we), 16'd0);
    chk("rst_reg_re", 16'(reg_re), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    hw(4);

    // Write 0xA5, 0x5A starting at pointer 0x10
    i2c_start();
    write_byte(8'h54, 8'h00, 8'h00, a); chk("wr_addr_ack", 16'(a), 16'd0);
    chk("wr_busy", 16'(busy), 16'd1);
    write_byte(8'h10, 8'h00, 8'h00, a); chk("wr_ptr_ack", 16'(a), 16'd0);
    exp_we.push_back(16'h10A5);
    write_byte(8'hA5, 8'h00, 8'h00, a); chk("wr_d0_ack", 16'(a), 16'd0);
    exp_we.push_back(16'h115A);
    write_byte(8'h5A, 8'h00, 8'h00, a); chk("wr_d1_ack", 16'(a), 16'd0);
    i2c_stop();
    chk("wr_reg_addr", 16'(reg_addr), 16'h12);
    chk("wr_busy_off", 16'(busy), 16'd0);
    chk("wr_we_count", 16'(n_we), 16'd2);

    // Pointer 0x20, repeated START, read two bytes
    r0 = n_re;
    i2c_start();
    write_byte(8'h54, 8'h00, 8'h00, a); chk("rd_addr_ack", 16'(a), 16'd0);
    write_byte(8'h20, 8'h00, 8'h00, a); chk("rd_ptr_ack", 16'(a), 16'd0);
    i2c_start();
    write_byte(8'h55, 8'h00, 8'h00, a); chk("rd_addr_r_ack", 16'(a), 16'd0);
    exp_rd.push_back(8'hC3);
    exp_rd.push_back(8'h3C);
    read_byte(1'b0, rb); chk("rd_byte0", 16'(rb), 16'(exp_rd.pop_front()));
    read_byte(1'b1, rb); chk("rd_byte1", 16'(rb), 16'(exp_rd.pop_front()));
    chk("rd_sda_released", 16'(sda_t), 16'd1);
    chk("rd_busy_nack", 16'(busy), 16'd0);
    i2c_stop();
    chk("rd_reg_addr", 16'(reg_addr), 16'h22);
    chk("rd_re_count", 16'(n_re - r0), 16'd2);

    // Address mismatch
    sda_low_seen = 1'b0;
    w0 = n_we;
    r0 = n_re;
    i2c_start();
    write_byte(8'h56, 8'h00, 8'h00, a); chk("mm_addr_nack", 16'(a), 16'd1);
    write_byte(8'h00, 8'h00, 8'h00, a); chk("mm_data_nack", 16'(a), 16'd1);
    i2c_stop();
    chk("mm_sda_never_low", 16'(sda_low_seen), 16'd0);
    chk("mm_no_we", 16'(n_we - w0), 16'd0);
    chk("mm_no_re", 16'(n_re - r0), 16'd0);
    chk("mm_busy", 16'(busy), 16'd0);

    // Pointer wrap FF -> 00
    i2c_start();
    write_byte(8'h54, 8'h00, 8'h00, a); chk("wrap_addr_ack", 16'(a), 16'd0);
    write_byte(8'hFF, 8'h00, 8'h00, a);
    exp_we.push_back(16'hFF11);
    write_byte(8'h11, 8'h00, 8'h00, a);
    exp_we.push_back(16'h0022);
    write_byte(8'h22, 8'h00, 8'h00, a); chk("wrap_d1_ack", 16'(a), 16'd0);
    i2c_stop();
    chk("wrap_reg_addr", 16'(reg_addr), 16'h01);

    // Single-clk glitches while idle and during bytes
    scl_m = 1'b0; hw(1); scl_m = 1'b1; hw(H);
    sda_m = 1'b0; hw(1); sda_m = 1'b1; hw(H);
    chk("gl_idle_busy", 16'(busy), 16'd0);
    i2c_start();
    write_byte(8'h54, 8'hA5, 8'h5A, a); chk("gl_addr_ack", 16'(a), 16'd0);
    write_byte(8'h30, 8'h00, 8'h00, a);
    exp_we.push_back(16'h3096);
    write_byte(8'h96, 8'hFF, 8'hFF, a); chk("gl_data_ack", 16'(a), 16'd0);
    i2c_stop();
    chk("gl_reg_addr", 16'(reg_addr), 16'h31);

    // Reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h54 >> i), 1'b0, 1'b0);
    for (int i = 0; i < 40 && sda_t !== 1'b0; i++) hw(1);
    chk("rst_ack_driven", 16'(sda_t), 16'd0);
    reset = 1'b1;
    hw(1);
    chk("rst_sda_release", 16'(sda_t), 16'd1);
    chk("rst_busy_clear", 16'(busy), 16'd0);
    reset = 1'b0;
    hw(H);
    i2c_stop();
    i2c_start();
    write_byte(8'h54, 8'h00, 8'h00, a); chk("post_rst_ack", 16'(a), 16'd0);
    write_byte(8'h40, 8'h00, 8'h00, a);
    exp_we.push_back(16'h4077);
    write_byte(8'h77, 8'h00, 8'h00, a); chk("post_rst_d_ack", 16'(a), 16'd0);
    i2c_stop();
    chk("post_rst_reg_addr", 16'(reg_addr), 16'h41);

    chk("we_pending", 16'(exp_we.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
